// File: rtl/proc_io_pkg.sv
// Shared types and widths for the Processor user-I/O sequencer.
package proc_io_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned FSM_W   = 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [FSM_W-1:0] {
        IDLE    = 3'd0,
        WAIT_IN = 3'd1,
        PULSE   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } seq_state_e;

    // States in which a run is in progress and Halt is honoured.
    function automatic logic is_run_state(input seq_state_e s);
        return (s == WAIT_IN) || (s == PULSE) || (s == RELEASE);
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// Single-clock synchronous FIFO with show-ahead head output.
// A push while full is accepted only when a pop happens in the same cycle.
module seq_fifo
    import proc_io_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Accept/advance decisions; a pop frees the slot a full-time push needs.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    // Pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/proc_input_sequencer.sv
// Drives the Processor's Enter/Minput handshake from a queue of operands
// and captures Moutput when Halt rises.
// Optional result comparator: define PROC_SEQ_CHECK_EN to add expected/pass/fail.
module proc_input_sequencer
    import proc_io_pkg::*;
#(
    parameter int unsigned        DEPTH        = 8,
    parameter logic [STATE_W-1:0] IN_STATE     = 4'h1,
    parameter int unsigned        ENTER_CYCLES = 1,
    parameter int unsigned        TIMEOUT      = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [DATA_W-1:0]  push_data,
    output logic               full,
    input  logic               start,
    input  logic [STATE_W-1:0] proc_state,
    input  logic               proc_halt,
    input  logic [DATA_W-1:0]  proc_out,
    output logic               proc_enter,
    output logic [DATA_W-1:0]  proc_data,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [DATA_W-1:0]  result,
    output logic [CNT_W-1:0]   sent_cnt
`ifdef PROC_SEQ_CHECK_EN
    ,
    input  logic [DATA_W-1:0]  expected,
    output logic               pass,
    output logic               fail
`endif
);

    localparam int unsigned EC_W = $clog2(ENTER_CYCLES + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [EC_W-1:0] ENTER_LEN = EC_W'(ENTER_CYCLES);
    localparam logic [TO_W-1:0] TMO_MAX   = TO_W'(TIMEOUT);

    seq_state_e          state_q, state_d;
    logic [EC_W-1:0]     enter_cnt_q, enter_cnt_d;
    logic [TO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                proc_enter_q, proc_enter_d;
    logic [DATA_W-1:0]   proc_data_q, proc_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]    sent_cnt_q, sent_cnt_d;

    logic                fifo_pop;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_head;
    logic                in_state;
    logic                halt_take;
    logic                run_start;
    logic                waiting;

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (full),
        .empty     (fifo_empty)
    );

    // Next-state and output decode; Halt overrides every other transition.
    always_comb begin
        state_d      = state_q;
        enter_cnt_d  = enter_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        proc_enter_d = 1'b0;
        proc_data_d  = proc_data_q;
        busy_d       = busy_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        result_d     = result_q;
        sent_cnt_d   = sent_cnt_q;
        fifo_pop     = 1'b0;

        in_state  = (proc_state == IN_STATE);
        halt_take = is_run_state(state_q) && proc_halt;
        run_start = ((state_q == IDLE) || (state_q == DONE)) && start;
        waiting   = (state_q == WAIT_IN) || (state_q == RELEASE);

        if (halt_take) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = proc_out;
        end else if (run_start) begin
            state_d    = WAIT_IN;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            timeout_d  = 1'b0;
            sent_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                end
                WAIT_IN: begin
                    // Data is loaded one cycle ahead of Enter rising.
                    if (in_state && !fifo_empty) begin
                        fifo_pop    = 1'b1;
                        proc_data_d = fifo_head;
                        enter_cnt_d = '0;
                        state_d     = PULSE;
                        if (sent_cnt_q != '1) begin
                            sent_cnt_d = sent_cnt_q + CNT_W'(1);
                        end
                    end
                end
                PULSE: begin
                    if (enter_cnt_q < ENTER_LEN) begin
                        proc_enter_d = 1'b1;
                        enter_cnt_d  = enter_cnt_q + EC_W'(1);
                    end else begin
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for the Processor to leave its input state so a
                    // lingering Enter is not taken as a second operand.
                    if (!in_state) begin
                        state_d = WAIT_IN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Wait-state watchdog: restarts on any state change, flag is sticky.
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (waiting) begin
            if (tmo_cnt_q != TMO_MAX) begin
                tmo_cnt_d = tmo_cnt_q + TO_W'(1);
            end
            if (tmo_cnt_d == TMO_MAX) begin
                timeout_d = 1'b1;
            end
        end
    end

    // State and registered outputs; synchronous reset aborts any run.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            enter_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
            proc_enter_q <= 1'b0;
            proc_data_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            result_q     <= '0;
            sent_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            enter_cnt_q  <= enter_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            proc_enter_q <= proc_enter_d;
            proc_data_q  <= proc_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            result_q     <= result_d;
            sent_cnt_q   <= sent_cnt_d;
        end
    end

    assign proc_enter = proc_enter_q;
    assign proc_data  = proc_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign result     = result_q;
    assign sent_cnt   = sent_cnt_q;

`ifdef PROC_SEQ_CHECK_EN
    logic pass_q, pass_d;
    logic fail_q, fail_d;

    // Verdict latched alongside done; cleared when a new run starts.
    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        if (halt_take) begin
            pass_d = (proc_out == expected);
            fail_d = (proc_out != expected);
        end else if (run_start) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
        end
    end

    // Verdict registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
        end
    end

    assign pass = pass_q;
    assign fail = fail_q;
`endif

endmodule

// File: tb/tb_proc_input_sequencer.sv
// Randomized self-checking bench for proc_input_sequencer with a Processor
// handshake model and a queue-based operand scoreboard.
module tb_proc_input_sequencer;

    localparam int unsigned DEPTH        = 8;
    localparam logic [3:0]  IN_ST        = 4'h1;
    localparam int unsigned ENTER_CYCLES = 3;
    localparam int unsigned TIMEOUT      = 16;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       push       = 1'b0;
    logic [7:0] push_data  = 8'h00;
    logic       start      = 1'b0;
    logic [3:0] proc_state = 4'h0;
    logic       proc_halt  = 1'b0;
    logic [7:0] proc_out   = 8'h00;
    logic       full, proc_enter, busy, done, timeout;
    logic [7:0] proc_data, result;
    logic [3:0] sent_cnt;
`ifdef PROC_SEQ_CHECK_EN
    logic [7:0] expected = 8'h00;
    logic       pass, fail;
`endif

    int         n_checks   = 0;
    int         n_fail     = 0;
    logic [7:0] exp_q[$];
    int         pulses     = 0;
    int         run_len    = 0;
    logic       mon_on     = 1'b0;
    logic       prev_enter = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always #5 clock = ~clock;

    proc_input_sequencer #(
        .DEPTH        (DEPTH),
        .IN_STATE     (IN_ST),
        .ENTER_CYCLES (ENTER_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .full       (full),
        .start      (start),
        .proc_state (proc_state),
        .proc_halt  (proc_halt),
        .proc_out   (proc_out),
        .proc_enter (proc_enter),
        .proc_data  (proc_data),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .result     (result),
        .sent_cnt   (sent_cnt)
`ifdef PROC_SEQ_CHECK_EN
        ,
        .expected   (expected),
        .pass       (pass),
        .fail       (fail)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] other_state();
        logic [3:0] s;
        do s = 4'($urandom_range(0, 15)); while (s == IN_ST);
        return s;
    endfunction

    // Handshake monitor: every Enter pulse must carry the next queued operand,
    // with data settled a cycle early, held through and after the pulse.
    always @(negedge clock) begin
        if (mon_on) begin
            if (proc_enter && !prev_enter) begin
                check_eq("data_setup", 32'(proc_data), 32'(prev_data));
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pulse", 32'(proc_enter), 32'd0);
                end else begin
                    check_eq("op_data", 32'(proc_data), 32'(exp_q.pop_front()));
                end
                pulses++;
                run_len = 1;
            end else if (proc_enter) begin
                check_eq("data_in_pulse", 32'(proc_data), 32'(prev_data));
                run_len++;
            end else if (prev_enter) begin
                check_eq("enter_len", 32'(run_len), 32'(ENTER_CYCLES));
                check_eq("data_after", 32'(proc_data), 32'(prev_data));
            end
        end
        prev_enter = proc_enter;
        prev_data  = proc_data;
    end

    task automatic push_op(input logic [7:0] v);
        push = 1'b1;
        push_data = v;
        tick();
        push = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(v);
        check_eq("full_after_push", 32'(full), 32'(exp_q.size() == DEPTH));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Processor model: enter input state, take one operand, optionally linger.
    task automatic proc_take(input int hold);
        int n;
        proc_state = IN_ST;
        n = 0;
        while (proc_enter !== 1'b1 && n < 100) begin tick(); n++; end
        check_eq("enter_seen", 32'(proc_enter), 32'd1);
        n = 0;
        while (proc_enter === 1'b1 && n < 50) begin tick(); n++; end
        repeat (hold) tick();
        proc_state = other_state();
        repeat ($urandom_range(1, 3)) tick();
    endtask

    // Halt held two cycles with a changing Moutput; only the first is captured.
    task automatic proc_do_halt(input logic [7:0] v, input bit match);
`ifdef PROC_SEQ_CHECK_EN
        expected = match ? v : (v ^ 8'h5A);
`endif
        proc_out  = v;
        proc_halt = 1'b1;
        tick();
        proc_out = match ? ~v : (v ^ 8'h3C);
        tick();
        proc_halt = 1'b0;
        check_eq("done", 32'(done), 32'd1);
        check_eq("result", 32'(result), 32'(v));
        check_eq("busy_after_halt", 32'(busy), 32'd0);
`ifdef PROC_SEQ_CHECK_EN
        check_eq("pass", 32'(pass), 32'(match));
        check_eq("fail", 32'(fail), 32'(!match));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_enter"},   32'(proc_enter), 32'd0);
        check_eq({tag, "_data"},    32'(proc_data),  32'd0);
        check_eq({tag, "_busy"},    32'(busy),       32'd0);
        check_eq({tag, "_done"},    32'(done),       32'd0);
        check_eq({tag, "_timeout"}, 32'(timeout),    32'd0);
        check_eq({tag, "_result"},  32'(result),     32'd0);
        check_eq({tag, "_sent"},    32'(sent_cnt),   32'd0);
        check_eq({tag, "_full"},    32'(full),       32'd0);
`ifdef PROC_SEQ_CHECK_EN
        check_eq({tag, "_pass"},    32'(pass),       32'd0);
        check_eq({tag, "_fail"},    32'(fail),       32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, k, n, sz;
        logic [7:0] v;

        // Reset state
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check_all_zero("reset");
        mon_on = 1'b1;

        // Two operands, lingering in the input state after each Enter
        p0 = pulses;
        push_op(8'd2);
        push_op(8'd8);
        pulse_start();
        check_eq("busy_start", 32'(busy), 32'd1);
        proc_take(3);
        proc_take(2);
        check_eq("two_pulses", 32'(pulses - p0), 32'd2);
        check_eq("sent_two", 32'(sent_cnt), 32'd2);
        proc_do_halt(8'd5, 1'b1);

        // Halt wins over a same-cycle pop; the operand stays queued
        p0 = pulses;
        push_op(8'h33);
        pulse_start();
        proc_state = IN_ST;
        proc_halt  = 1'b1;
        proc_out   = 8'hA5;
        tick();
        proc_halt = 1'b0;
        check_eq("prio_done", 32'(done), 32'd1);
        check_eq("prio_result", 32'(result), 32'hA5);
        check_eq("prio_sent", 32'(sent_cnt), 32'd0);
        repeat (4) tick();
        check_eq("prio_no_pulse", 32'(pulses - p0), 32'd0);
        proc_state = other_state();

        // Randomized runs: leftover operands carry into the next run
        for (int r = 0; r < 6; r++) begin
            sz = exp_q.size();
            n = (sz >= DEPTH) ? 0 : $urandom_range(1, DEPTH - sz);
            for (int i = 0; i < n; i++) push_op(8'($urandom));
            pulse_start();
            check_eq("run_busy", 32'(busy), 32'd1);
            check_eq("run_done_clr", 32'(done), 32'd0);
            check_eq("run_sent_clr", 32'(sent_cnt), 32'd0);
            sz = exp_q.size();
            k = $urandom_range(1, sz);
            p0 = pulses;
            for (int i = 0; i < k; i++) proc_take($urandom_range(0, 3));
            check_eq("run_pulses", 32'(pulses - p0), 32'(k));
            check_eq("run_sent", 32'(sent_cnt), 32'(k));
            check_eq("run_left", 32'(exp_q.size()), 32'(sz - k));
            v = 8'($urandom);
            proc_do_halt(v, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of an Enter pulse
        if (exp_q.size() == 0) push_op(8'h5C);
        pulse_start();
        proc_state = IN_ST;
        n = 0;
        while (proc_enter !== 1'b1 && n < 50) begin tick(); n++; end
        check_eq("pre_reset_enter", 32'(proc_enter), 32'd1);
        mon_on = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("mid_reset");
        exp_q.delete();
        tick();
        mon_on = 1'b1;

        // Nothing runs without start, even in the input state
        p0 = pulses;
        repeat (10) tick();
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_no_pulse", 32'(pulses - p0), 32'd0);

        // Empty FIFO in the input state: flag only after TIMEOUT cycles
        pulse_start();
        repeat (TIMEOUT - 1) tick();
        check_eq("tmo_early", 32'(timeout), 32'd0);
        tick();
        check_eq("tmo_set", 32'(timeout), 32'd1);
        check_eq("tmo_busy", 32'(busy), 32'd1);
        check_eq("tmo_fifo_empty", 32'(pulses - p0), 32'd0);
        push_op(8'h77);
        proc_take(1);
        check_eq("tmo_delivered", 32'(pulses - p0), 32'd1);
        check_eq("tmo_sticky", 32'(timeout), 32'd1);
        proc_do_halt(8'h77, 1'b0);

        // Overfill, then push and pop in the same cycle while full
        for (int i = 0; i < DEPTH + 1; i++) push_op(8'(8'h10 + i));
        check_eq("overfill_q", 32'(exp_q.size()), 32'(DEPTH));
        p0 = pulses;
        proc_state = IN_ST;
        pulse_start();
        push = 1'b1;
        push_data = 8'hEE;
        tick();
        push = 1'b0;
        sz = exp_q.size() - 1 + 1;
        exp_q.push_back(8'hEE);
        check_eq("full_push_pop", 32'(full), 32'(sz == DEPTH));
        check_eq("start_clr_tmo", 32'(timeout), 32'd0);
        for (int i = 0; i < DEPTH + 1; i++) proc_take($urandom_range(0, 2));
        check_eq("drain_pulses", 32'(pulses - p0), 32'(DEPTH + 1));
        check_eq("drain_sent", 32'(sent_cnt), 32'(DEPTH + 1));
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        check_eq("drain_full", 32'(full), 32'd0);
        proc_do_halt(8'h9D, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
